// File: rtl/ccff_loader_pkg.sv
// Shared types and CRC-16-CCITT constants for the configuration-chain loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } ccff_ld_state_t;

    localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
    localparam logic [15:0] CCFF_CRC_INIT = 16'hFFFF;

    // One serial CRC-16-CCITT step, MSB-first, no reflection.
    function automatic logic [15:0] ccff_crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// Serial CRC-16-CCITT accumulator over the bits driven into the config chain.
module ccff_crc16_serial
    import ccff_loader_pkg::*;
(
    input  logic        prog_clk,
    input  logic        pReset_n,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init) begin
            crc_d = CCFF_CRC_INIT;
        end else if (en) begin
            crc_d = ccff_crc16_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc_q <= CCFF_CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream words MSB-first into a CHAIN_LEN-bit configuration chain.
// Optional CRC check over the shifted bits is enabled by defining CCFF_LOADER_CRC_EN.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CHAIN_LEN = 16,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              chain_clk_en,
    output logic              busy,
    output logic              done,
    input  logic [15:0]       crc_expect,
    output logic              crc_ok
);

    localparam int unsigned WC_W = $clog2(WORD_W + 1);

    ccff_ld_state_t    state_q, state_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wcnt_d  = wcnt_q;
        sreg_d  = sreg_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    rem_d   = CNT_W'(CHAIN_LEN);
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (bs_valid) begin
                    sreg_d  = bs_data;
                    // A short final word only shifts its top 'remaining' bits.
                    wcnt_d  = (32'(rem_q) >= WORD_W) ? WC_W'(WORD_W) : WC_W'(rem_q);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sreg_d = {sreg_q[WORD_W-2:0], 1'b0};
                rem_d  = rem_q - CNT_W'(1);
                wcnt_d = wcnt_q - WC_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else if (wcnt_q == WC_W'(1)) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_FETCH) || (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            wcnt_q  <= '0;
            sreg_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wcnt_q  <= wcnt_d;
            sreg_q  <= sreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bs_ready     = (state_q == ST_FETCH);
    assign chain_clk_en = (state_q == ST_SHIFT);
    assign ccff_head    = chain_clk_en & sreg_q[WORD_W-1];
    assign busy         = busy_q;
    assign done         = done_q;

`ifdef CCFF_LOADER_CRC_EN
    logic        crc_init;
    logic [15:0] crc_val;
    logic        crc_ok_q;

    assign crc_init = start && !busy_q;

    ccff_crc16_serial u_crc (
        .prog_clk (prog_clk),
        .pReset_n (pReset_n),
        .init     (crc_init),
        .en       (chain_clk_en),
        .bit_in   (ccff_head),
        .crc      (crc_val)
    );

    // Drops together with done on a restart instead of lingering a cycle.
    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            crc_ok_q <= 1'b0;
        end else begin
            crc_ok_q <= done_q && (state_d == ST_DONE) && (crc_val == crc_expect);
        end
    end

    assign crc_ok = crc_ok_q;
`else
    logic unused_crc_expect;
    assign unused_crc_expect = ^crc_expect;
    assign crc_ok            = done_q;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader: default 16-bit chain and a 12-bit partial-word chain.
module tb_ccff_bitstream_loader;

    logic        clk;
    logic        pReset_n;
    logic        start_a, start_b;
    logic        bs_valid;
    logic [7:0]  bs_data;
    logic [15:0] crc_expect;

    logic a_ready, a_head, a_en, a_busy, a_done, a_crc_ok;
    logic b_ready, b_head, b_en, b_busy, b_done, b_crc_ok;

    logic [15:0] chain_a;
    logic [11:0] chain_b;

    int unsigned n_checks;
    int unsigned n_err;

    int unsigned en_cnt, done_cyc, acc0, acc1, nacc, st_seen, stall_en;
    logic [31:0] heads, en_mask, busy_mask;

    ccff_bitstream_loader u_dut_a (
        .prog_clk     (clk),
        .pReset_n     (pReset_n),
        .start        (start_a),
        .bs_valid     (bs_valid),
        .bs_data      (bs_data),
        .bs_ready     (a_ready),
        .ccff_head    (a_head),
        .chain_clk_en (a_en),
        .busy         (a_busy),
        .done         (a_done),
        .crc_expect   (crc_expect),
        .crc_ok       (a_crc_ok)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12)) u_dut_b (
        .prog_clk     (clk),
        .pReset_n     (pReset_n),
        .start        (start_b),
        .bs_valid     (bs_valid),
        .bs_data      (bs_data),
        .bs_ready     (b_ready),
        .ccff_head    (b_head),
        .chain_clk_en (b_en),
        .busy         (b_busy),
        .done         (b_done),
        .crc_expect   (crc_expect),
        .crc_ok       (b_crc_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream chain: bit 0 sits at ccff_head, the top bit nearest ccff_tail.
    always @(posedge clk) begin
        if (a_en) chain_a <= {chain_a[14:0], a_head};
        if (b_en) chain_b <= {chain_b[10:0], b_head};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_crc(input logic [15:0] data);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[15] ^ data[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Called at a falling edge; start is sampled at the next rising edge (cycle T = 0).
    task automatic run_load(input bit sel, input logic [7:0] w0, input logic [7:0] w1,
                            input int unsigned stall, input int unsigned spur_c,
                            input int unsigned nc);
        logic rdy, en, hd, bsy, dn;
        bit   pend;
        en_cnt = 0; done_cyc = 0; acc0 = 0; acc1 = 0; nacc = 0; st_seen = 0; stall_en = 0;
        heads = '0; en_mask = '0; busy_mask = '0; pend = 0;
        bs_data  = w0;
        bs_valid = 1'b1;
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        for (int unsigned c = 1; c <= nc; c++) begin
            if (pend) begin
                bs_data = (nacc == 1) ? w1 : 8'h00;
                if (stall != 0 && nacc == 1) bs_valid = 1'b0;
                pend = 0;
            end
            if (sel) start_b = (c == spur_c); else start_a = (c == spur_c);
            rdy = sel ? b_ready : a_ready;
            en  = sel ? b_en    : a_en;
            hd  = sel ? b_head  : a_head;
            bsy = sel ? b_busy  : a_busy;
            dn  = sel ? b_done  : a_done;
            if (en) begin
                en_cnt++;
                heads      = {heads[30:0], hd};
                en_mask[c] = 1'b1;
            end
            if (bsy) busy_mask[c] = 1'b1;
            if (dn && done_cyc == 0) done_cyc = c;
            if (rdy && !bs_valid) begin
                if (st_seen == stall) bs_valid = 1'b1;
                else begin
                    st_seen++;
                    if (en) stall_en++;
                end
            end
            if (rdy && bs_valid) begin
                if (nacc == 0) acc0 = c;
                else if (nacc == 1) acc1 = c;
                nacc++;
                pend = 1;
            end
            @(negedge clk);
        end
        start_a  = 1'b0;
        start_b  = 1'b0;
        bs_valid = 1'b0;
    endtask

    task automatic check_default_load(input string tag);
        check_eq({tag, "_acc0"},  acc0, 1);
        check_eq({tag, "_acc1"},  acc1, 10);
        check_eq({tag, "_nacc"},  nacc, 2);
        check_eq({tag, "_encnt"}, en_cnt, 16);
        check_eq({tag, "_heads"}, heads, 32'h0000_A53C);
        check_eq({tag, "_enmsk"}, en_mask, 32'h0007_FBFC);
        check_eq({tag, "_bsymk"}, busy_mask, 32'h0007_FFFE);
        check_eq({tag, "_done"},  done_cyc, 19);
        check_eq({tag, "_chain"}, chain_a, 16'hA53C);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        pReset_n = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bs_valid = 1'b0;
        bs_data  = '0;
        crc_expect = ref_crc(16'hA53C);
        chain_a  = '0;
        chain_b  = '0;
        repeat (2) @(negedge clk);
        pReset_n = 1'b1;
        @(negedge clk);

        check_eq("rst_ready", a_ready,  0);
        check_eq("rst_head",  a_head,   0);
        check_eq("rst_en",    a_en,     0);
        check_eq("rst_busy",  a_busy,   0);
        check_eq("rst_done",  a_done,   0);
        check_eq("rst_crcok", a_crc_ok, 0);

        // A word offered while idle must not be taken.
        bs_valid = 1'b1;
        bs_data  = 8'h77;
        @(negedge clk);
        check_eq("idle_ready", a_ready, 0);
        bs_valid = 1'b0;

        run_load(0, 8'hA5, 8'h3C, 0, 0, 22);
        check_default_load("b2b");
        check_eq("b2b_crcok", a_crc_ok, 1);
        crc_expect = crc_expect ^ 16'h0100;
        repeat (2) @(negedge clk);
`ifdef CCFF_LOADER_CRC_EN
        check_eq("crc_flip", a_crc_ok, 0);
`else
        check_eq("crc_flip", a_crc_ok, 1);
`endif
        crc_expect = ref_crc(16'hA53C);

        run_load(0, 8'hA5, 8'h3C, 0, 4, 22);
        check_default_load("spur");

        run_load(0, 8'hA5, 8'h3C, 5, 0, 28);
        check_eq("stall_seen",  st_seen, 5);
        check_eq("stall_en",    stall_en, 0);
        check_eq("stall_acc1",  acc1, 15);
        check_eq("stall_enmsk", en_mask, 32'h00FF_03FC);
        check_eq("stall_done",  done_cyc, 24);
        check_eq("stall_heads", heads, 32'h0000_A53C);

        run_load(1, 8'hFF, 8'hF0, 0, 0, 18);
        check_eq("part_encnt", en_cnt, 12);
        check_eq("part_enmsk", en_mask, 32'h0000_7BFC);
        check_eq("part_last4", heads[3:0], 4'hF);
        check_eq("part_heads", heads, 32'h0000_0FFF);
        check_eq("part_done",  done_cyc, 15);
        check_eq("part_chain", chain_b, 12'hFFF);

        // Reset in the middle of shifting the first word.
        bs_data  = 8'hA5;
        bs_valid = 1'b1;
        start_a  = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        en_cnt  = 0;
        for (int i = 0; i < 20 && en_cnt < 5; i++) begin
            if (a_en) en_cnt++;
            if (en_cnt < 5) @(negedge clk);
        end
        check_eq("mid_bits", en_cnt, 5);
        #2 pReset_n = 1'b0;
        #1;
        check_eq("mid_outs", {a_ready, a_head, a_en, a_busy, a_done, a_crc_ok}, 0);
        @(negedge clk);
        pReset_n = 1'b1;
        bs_valid = 1'b0;
        @(negedge clk);
        check_eq("post_rst_busy", a_busy, 0);
        run_load(0, 8'hA5, 8'h3C, 0, 0, 22);
        check_default_load("rld");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ccff_bitstream_loader.md
# ccff_bitstream_loader

Configuration-chain driver that sits directly upstream of the routing-block memories, e.g. the connection-block mux memory chain. It accepts bitstream words from the programming interface over a valid/ready handshake. It serializes each word MSB-first onto `ccff_head` and asserts a per-bit clock enable for the gated `prog_clk` that feeds the chain. After exactly `CHAIN_LEN` bits it stops and reports `done`, with an optional CRC check over the shifted bits.

## Interface
- `WORD_W`, default 8: bitstream word width, ≥ 2.
- `CHAIN_LEN`, default 16: total configuration bits in the downstream chain (4 muxes × 4 mem bits), ≥ 1.
- `CNT_W`, default `$clog2(CHAIN_LEN+1)`: width of the remaining-bit counter.
- `prog_clk`  in  1  programming clock; all state on the rising edge.
- `pReset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle request to begin a load; ignored while `busy`.
- `bs_valid`  in  1  bitstream word valid.
- `bs_data`  in  `WORD_W`  bitstream word; bit `WORD_W-1` is shifted first.
- `bs_ready`  out  1  loader can accept a word.
- `ccff_head`  out  1  serial config bit into the chain.
- `chain_clk_en`  out  1  enable for the chain's clock gate; chain shifts only when 1.
- `busy`  out  1  load in progress.
- `done`  out  1  load complete; held until next `start`.
- `crc_expect`  in  16  expected CRC of the shifted bit stream.
- `crc_ok`  out  1  CRC match flag, valid while `done`.

## Operation
- States: IDLE, FETCH, SHIFT, DONE.
- **IDLE / DONE**
  - `start` loads the remaining-bit counter with `CHAIN_LEN` and clears `done`.
  - It also re-initializes the CRC, then moves to FETCH.
- **FETCH**
  - `bs_ready`=1.
  - On `bs_valid && bs_ready`, latch `bs_data` into the shift register.
  - Set the word-bit counter to min(`WORD_W`, remaining), then go to SHIFT.
- **SHIFT**
  - `ccff_head` = shift register MSB and `chain_clk_en`=1.
  - The shift register shifts left and both counters decrement.
  - If the word-bit counter reaches 0 with remaining > 0, go to FETCH.
  - If remaining reaches 0, go to DONE.
- Partial last word: when `CHAIN_LEN` mod `WORD_W` ≠ 0, only the top (remaining) bits of the last word are shifted; the low bits are discarded.
- Bit placement: the first bit shifted ends in the last memory bit of the chain (nearest `ccff_tail`). The host supplies the bitstream in that order.
- Outside SHIFT: `chain_clk_en`=0 and `ccff_head`=0, so the chain holds its contents across fetch bubbles and idle periods.
- `start` while `busy` is ignored and has no side effects.
- A word presented in IDLE or DONE is not accepted (`bs_ready`=0).

## Timing
- Reset values:
  - State IDLE; `bs_ready`, `ccff_head`, `chain_clk_en`, `busy`, `done`, `crc_ok` all 0.
  - Counters 0; CRC register 0xFFFF.
- `start` at cycle T puts the block in FETCH at T+1.
- A handshake at cycle k gives shift cycles k+1 … k+n, with n = min(`WORD_W`, remaining).
- The next FETCH follows at k+n+1. Each word therefore costs one bubble cycle when `bs_valid` is held high.
- Default parameters with `bs_valid` held high:
  - Words accepted at T+1 and T+10.
  - `chain_clk_en` high T+2…T+9 and T+11…T+18.
  - `done`=1 from T+19.
- `busy` = state ∈ {FETCH, SHIFT}; it is registered together with the state.
- Host stall: `bs_valid` low in FETCH holds FETCH indefinitely with no chain clocks.
- Reset mid-load: everything returns to reset values on the next evaluation. Chain contents are then undefined and the host must re-issue `start`.

## Configuration
- `CCFF_LOADER_CRC_EN` defined:
  - A serial CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) updates on every cycle with `chain_clk_en`=1, using `ccff_head`.
  - `crc_ok` = `done` && (crc == `crc_expect`), registered.
- Undefined: no CRC logic; `crc_expect` is ignored and `crc_ok` = `done`.

## Structure
- `ccff_loader_pkg` holds:
  - the state enum `ccff_ld_state_t`;
  - CRC constants `CCFF_CRC_POLY` = 16'h1021 and `CCFF_CRC_INIT` = 16'hFFFF.
- One sub-module, `ccff_crc16_serial`:
  - ports `prog_clk`, `pReset_n`, `init`, `en`, `bit_in`, `crc`;
  - instantiated only under `CCFF_LOADER_CRC_EN`.

## Test plan
- **Back-to-back load, defaults:** `start`, words 0xA5 then 0x3C, `bs_valid` held high. Expect `ccff_head` sequence 1,0,1,0,0,1,0,1, then 0,0,1,1,1,1,0,0, and exactly 16 `chain_clk_en` cycles. Expect `done` at T+19, and a chain model holding the bits in first-in-deepest order.
- **Partial word, `CHAIN_LEN`=12:** words 0xFF then 0xF0. Expect 12 enables, with the last 4 shifted bits 1,1,1,1. The 0 nibble is never shifted, and `done` follows the last enable by one cycle.
- **Host stall:** drop `bs_valid` for 5 cycles before the second word. Expect `bs_ready` held, `chain_clk_en`=0 throughout the stall, and `done` delayed by exactly 5 cycles.
- **Spurious start:** pulse `start` during SHIFT. Expect no change in counters, outputs or the enable count.
- **Async reset mid-SHIFT:** drop `pReset_n` after 5 bits. Expect all outputs 0 immediately. A new `start` then completes a full 16-bit load correctly.
- **CRC, with `CCFF_LOADER_CRC_EN`:** words 0xA5, 0x3C; `crc_expect` = 16-bit CRC of 0xA53C computed by the reference model. Expect `crc_ok`=1; flipping one `crc_expect` bit gives `crc_ok`=0.
